// File: rtl/filter_mem_pkg.sv
// filter_mem_pkg
//   Shared definitions for the filter vector fetch path: fetch FSM state
//   encoding, default data/address widths and a width helper used to size
//   counters from their maximum value count.
package filter_mem_pkg;

    typedef enum logic [1:0] {
        LOAD_B   = 2'd0,
        STREAM_M = 2'd1,
        DONE     = 2'd2
    } fetch_state_e;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 10;

    // Bits needed to hold n distinct values (ceil(log2(n)), minimum 1).
    function automatic int width_of(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/filter_vector_fetch_arbiter_bias_cache_regs.sv
// bias_cache_regs
//   Register file holding the cached bias elements. One indexed write per
//   cycle; each slot carries a valid flag set on its first write.
//   Ports:
//     clock, clear       clock / synchronous active-high reset
//     wr_en, wr_idx      write strobe and slot index
//     wr_data            element to store
//     b_cached           per-slot valid flags
//     b_data             slot i at bits [i*DATA_W +: DATA_W]
module bias_cache_regs #(
    parameter int NUM_B  = 4,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 3
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [NUM_B-1:0]         b_cached,
    output logic [NUM_B*DATA_W-1:0]  b_data
);

    logic [NUM_B-1:0][DATA_W-1:0] slot_q;

    always_ff @(posedge clock) begin
        if (clear) begin
            slot_q   <= '0;
            b_cached <= '0;
        end else begin
            for (int i = 0; i < NUM_B; i++) begin
                if (wr_en && (wr_idx == IDX_W'(i))) begin
                    slot_q[i]   <= wr_data;
                    b_cached[i] <= 1'b1;
                end
            end
        end
    end

    assign b_data = slot_q;

endmodule

// File: rtl/filter_vector_fetch_arbiter.sv
// filter_vector_fetch_arbiter
//   Owns the single read port of the shared vector memory. First loads NUM_B
//   bias elements into a register cache, then streams M_LEN m elements to the
//   MAC datapath, one per accepted m_req (at most one every 2 cycles).
//   Optional macro FILTER_FETCH_WRAP_EN: after the last m element the index
//   wraps and streaming continues; done pulses with m_last instead of holding.
//   Ports:
//     clock, clear        clock / synchronous active-high reset
//     en                  advance enable (low stops new reads being issued)
//     mem_addr, mem_en    read address / strobe (data back one cycle later)
//     mem_rdata           read data
//     m_req               consumer request for next m element
//     m_valid, m_data     one-cycle delivery pulse and element
//     m_last              marks element M_LEN-1
//     b_ready, b_cached   all-bias-cached flag / per-slot flags
//     b_data              cached bias vector
//     done                pass complete
module filter_vector_fetch_arbiter
    import filter_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_B  = 4,
    parameter int B_BASE = 0,
    parameter int M_BASE = 4,
    parameter int M_LEN  = 64
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     en,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_en,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     m_req,
    output logic                     m_valid,
    output logic [DATA_W-1:0]        m_data,
    output logic                     m_last,
    output logic                     b_ready,
    output logic [NUM_B-1:0]         b_cached,
    output logic [NUM_B*DATA_W-1:0]  b_data,
    output logic                     done
);

    localparam int KW = width_of(NUM_B + 1);
    localparam int IW = width_of(M_LEN + 1);
    localparam logic [KW-1:0] K_END  = KW'(NUM_B);
    localparam logic [KW-1:0] K_LAST = KW'(NUM_B - 1);
    localparam logic [IW-1:0] I_LAST = IW'(M_LEN - 1);

    fetch_state_e      state;
    logic [KW-1:0]     k;          // bias reads issued
    logic [KW-1:0]     pend_slot;  // cache slot of the bias read in flight
    logic [IW-1:0]     idx;        // m elements delivered this pass
    logic              pend;       // a read is in flight
    logic [ADDR_W-1:0] addr_q;     // last issued address, held while idle
    logic              b_issue;
    logic              m_issue;
    logic [ADDR_W-1:0] issue_addr;

    // Issue is combinational so an accepted m_req reaches memory in the same
    // cycle; clear blocks issue so outputs read 0 while it is held.
    always_comb begin
        b_issue    = !clear && en && (state == LOAD_B) && (k != K_END);
        m_issue    = !clear && en && m_req && (state == STREAM_M) && !pend;
        issue_addr = m_issue ? ADDR_W'(M_BASE) + ADDR_W'(idx)
                             : ADDR_W'(B_BASE) + ADDR_W'(k);
    end

    assign mem_en   = b_issue | m_issue;
    assign mem_addr = mem_en ? issue_addr : addr_q;

    bias_cache_regs #(
        .NUM_B  (NUM_B),
        .DATA_W (DATA_W),
        .IDX_W  (KW)
    ) u_bias (
        .clock    (clock),
        .clear    (clear),
        .wr_en    (pend && (state == LOAD_B)),
        .wr_idx   (pend_slot),
        .wr_data  (mem_rdata),
        .b_cached (b_cached),
        .b_data   (b_data)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= LOAD_B;
            k         <= '0;
            pend_slot <= '0;
            idx       <= '0;
            pend      <= 1'b0;
            addr_q    <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
            b_ready   <= 1'b0;
            done      <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
`ifdef FILTER_FETCH_WRAP_EN
            done    <= 1'b0;
`endif
            if (mem_en) addr_q <= issue_addr;
            case (state)
                LOAD_B: begin
                    // Capture of the final slot coincides with the state change.
                    if (pend && (pend_slot == K_LAST)) begin
                        state   <= STREAM_M;
                        b_ready <= 1'b1;
                    end
                    pend <= b_issue;
                    if (b_issue) begin
                        pend_slot <= k;
                        k         <= k + KW'(1);
                    end
                end
                STREAM_M: begin
                    if (pend) begin
                        pend    <= 1'b0;
                        m_valid <= 1'b1;
                        m_data  <= mem_rdata;
                        m_last  <= (idx == I_LAST);
                        if (idx == I_LAST) begin
                            done <= 1'b1;
`ifdef FILTER_FETCH_WRAP_EN
                            idx  <= '0;
`else
                            state <= DONE;
`endif
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else if (m_issue) begin
                        pend <= 1'b1;
                    end
                end
                default: pend <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_filter_vector_fetch_arbiter.sv
module tb_filter_vector_fetch_arbiter;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int NUM_B  = 4;
    localparam int B_BASE = 0;
    localparam int M_BASE = 4;
    localparam int M_LEN  = 3;

    logic clock = 1'b0;
    logic clear = 1'b1;
    logic en    = 1'b0;
    logic m_req = 1'b0;
    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_en;
    logic [DATA_W-1:0]       mem_rdata = '0;
    logic                    m_valid;
    logic [DATA_W-1:0]       m_data;
    logic                    m_last;
    logic                    b_ready;
    logic [NUM_B-1:0]        b_cached;
    logic [NUM_B*DATA_W-1:0] b_data;
    logic                    done;

    filter_vector_fetch_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_B(NUM_B),
        .B_BASE(B_BASE), .M_BASE(M_BASE), .M_LEN(M_LEN)
    ) dut (
        .clock(clock), .clear(clear), .en(en),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_rdata(mem_rdata),
        .m_req(m_req), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .b_ready(b_ready), .b_cached(b_cached), .b_data(b_data), .done(done)
    );

    always #5 clock = ~clock;

    // Synchronous-read memory: one cycle of latency.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clock) if (mem_en) mem_rdata <= mem[mem_addr];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [DATA_W-1:0] data;
        bit                last;
        int                due;
    } exp_t;
    exp_t q[$];

    int errors = 0;
    int checks = 0;
    bit started = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: what the spec says is visible after the latest edge.
    int phase;                 // 0 bias load, 1 streaming, 2 finished
    int bk;                    // bias reads issued
    int bslot;                 // bias slot in flight, -1 none
    int idx;                   // m elements delivered this pass
    bit mpend;                 // m read in flight
    bit mdone;
    bit bready;
    logic [NUM_B-1:0]  cached;
    logic [ADDR_W-1:0] last_addr;

    // Monitor: pops an expectation whenever the DUT presents an element.
    always @(negedge clock) begin
        exp_t e;
        if (started) begin
            if (m_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL m_valid_unexpected: got m_valid=1 data=%0h, expected no output (cycle %0d)", m_data, cyc);
                end else begin
                    e = q.pop_front();
                    chk("m_data", 64'(m_data), 64'(e.data));
                    chk("m_last", 64'(m_last), 64'(e.last));
                    chk("m_valid_cycle", 64'(cyc), 64'(e.due));
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL m_valid_missing: got m_valid=0, expected data %0h (cycle %0d)", q[0].data, cyc);
                void'(q.pop_front());
            end
        end
    end

    // Drive one cycle of inputs, check the read port and registered outputs,
    // then advance the model across the coming edge.
    task automatic step(input bit c, input bit e, input bit r);
        logic [NUM_B*DATA_W-1:0] eb;
        bit exp_en;
        logic [ADDR_W-1:0] exp_addr;
        @(negedge clock);
        #1;
        clear = c; en = e; m_req = r;
        #1;
        if (started) begin
            eb = '0;
            for (int i = 0; i < NUM_B; i++)
                if (cached[i]) eb[i*DATA_W +: DATA_W] = mem[B_BASE + i];
            chk("b_cached", 64'(b_cached), 64'(cached));
            chk("b_data", 64'(b_data), 64'(eb));
            chk("b_ready", 64'(b_ready), 64'(bready));
            chk("done", 64'(done), 64'(mdone));
        end
        exp_en = 0;
        exp_addr = last_addr;
        if (!c) begin
            if (phase == 0) begin
                exp_en = e && (bk < NUM_B);
                exp_addr = ADDR_W'(B_BASE + bk);
            end else if (phase == 1) begin
                exp_en = r && e && !mpend;
                exp_addr = ADDR_W'(M_BASE + idx);
            end
        end
        chk("mem_en", 64'(mem_en), 64'(exp_en));
        if (started && !c) chk("mem_addr", 64'(mem_addr), 64'(exp_en ? exp_addr : last_addr));

        if (c) begin
            phase = 0; bk = 0; bslot = -1; idx = 0; mpend = 0; mdone = 0;
            bready = 0; cached = '0; last_addr = '0;
            q.delete();
            started = 1;
        end else begin
            if (exp_en) last_addr = exp_addr;
            if (phase == 0) begin
                if (bslot >= 0) begin
                    cached[bslot] = 1'b1;
                    if (bslot == NUM_B - 1) begin phase = 1; bready = 1; end
                end
                if (exp_en) begin bslot = bk; bk++; end
                else bslot = -1;
            end else if (phase == 1) begin
`ifdef FILTER_FETCH_WRAP_EN
                mdone = 0;
`endif
                if (mpend) begin
                    mpend = 0;
                    if (idx == M_LEN - 1) begin
                        mdone = 1;
`ifdef FILTER_FETCH_WRAP_EN
                        idx = 0;
`else
                        phase = 2;
`endif
                    end else idx++;
                end else if (exp_en) begin
                    q.push_back('{mem[M_BASE + idx], (idx == M_LEN - 1), cyc + 2});
                    mpend = 1;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'($urandom);
        mem[0] = 16'h0011; mem[1] = 16'h0022; mem[2] = 16'h0033; mem[3] = 16'h0044;
        mem[4] = 16'hA000; mem[5] = 16'hA001; mem[6] = 16'hA002;
        phase = 0; bk = 0; bslot = -1; idx = 0; mpend = 0; mdone = 0;
        bready = 0; cached = '0; last_addr = '0;

        // Full pass with en and m_req held high.
        step(1, 0, 0); step(1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 1);
        chk("b_data_full", 64'(b_data), 64'h0044_0033_0022_0011);

        // en stall after the second bias read is issued.
        step(1, 0, 0);
        step(0, 1, 0); step(0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 1'($urandom_range(0, 1)));

        // clear the cycle after an accepted request.
        step(1, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0);
        step(0, 1, 1);
        step(1, 1, 1);
        for (int i = 0; i < 16; i++) step(0, 1, 1);

        // Randomised episodes.
        for (int ep = 0; ep < 10; ep++) begin
            step(1, 0, 0);
            for (int i = 0; i < 60; i++)
                step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 8),
                     1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 4; i++) step(0, 0, 0);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
